// File: rtl/userio_pkg.sv
// Shared types and constants for the user-port joystick sequencers (DB15 serial chain, DB9MD).
package userio_pkg;

    localparam int JOY_BITS_PER_PLAYER = 12;
    localparam int JOY_PLAYERS         = 2;
    localparam int JOY_FRAME_BITS      = JOY_BITS_PER_PLAYER * JOY_PLAYERS;
    localparam int JOY_WORD_BITS       = 16;

    // Joystick word bit positions, matching the bit order used by emu's joystick logic.
    localparam int JB_R  = 0;
    localparam int JB_L  = 1;
    localparam int JB_D  = 2;
    localparam int JB_U  = 3;
    localparam int JB_B1 = 4;
    localparam int JB_B2 = 5;
    localparam int JB_B3 = 6;
    localparam int JB_B4 = 7;
    localparam int JB_B5 = 8;
    localparam int JB_B6 = 9;
    localparam int JB_B7 = 10;
    localparam int JB_B8 = 11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SHIFT_LO,
        SHIFT_HI,
        PUBLISH,
        GAP
    } db15_state_t;

    // Converts one player's 12 active-low chain bits into an active-high joystick word.
    function automatic logic [JOY_WORD_BITS-1:0] to_joy_word(
        input logic [JOY_BITS_PER_PLAYER-1:0] raw_n
    );
        logic [JOY_WORD_BITS-1:0] w;
        w        = '0;
        w[JB_R]  = ~raw_n[JB_R];
        w[JB_L]  = ~raw_n[JB_L];
        w[JB_D]  = ~raw_n[JB_D];
        w[JB_U]  = ~raw_n[JB_U];
        w[JB_B1] = ~raw_n[JB_B1];
        w[JB_B2] = ~raw_n[JB_B2];
        w[JB_B3] = ~raw_n[JB_B3];
        w[JB_B4] = ~raw_n[JB_B4];
        w[JB_B5] = ~raw_n[JB_B5];
        w[JB_B6] = ~raw_n[JB_B6];
        w[JB_B7] = ~raw_n[JB_B7];
        w[JB_B8] = ~raw_n[JB_B8];
        return w;
    endfunction

endpackage

// File: rtl/userio_tick_div.sv
// Free-running tick generator: one-cycle tick every CLK_DIV clocks, restartable via clr.
module userio_tick_div #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/userio_db15_seq.sv
// DB15 serial joystick adapter sequencer: loads and clocks the 24-bit shift chain,
// optionally filters frames, and publishes both player words in the same cycle.
module userio_db15_seq
    import userio_pkg::*;
#(
    parameter int CLK_DIV   = 16,   // clocks per tick (half JOY_CLK period), >= 2
    parameter int GAP_TICKS = 512,  // idle ticks between frames, >= 1
    parameter int FILTER    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     joy_data,
    output logic                     joy_clk,
    output logic                     joy_load,
    output logic [JOY_WORD_BITS-1:0] joystick1,
    output logic [JOY_WORD_BITS-1:0] joystick2,
    output logic                     frame_done
);

    localparam int               GAP_W    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
    localparam logic [4:0]       LAST_BIT = 5'(JOY_FRAME_BITS - 1);

    db15_state_t               state;
    logic [4:0]                bit_cnt;
    logic [GAP_W-1:0]          gap_cnt;
    logic [JOY_FRAME_BITS-1:0] shift_q;
    logic [JOY_FRAME_BITS-1:0] prev_q;
    logic                      tick;
    logic                      div_clr;

    // Restarting the divider in PUBLISH makes the gap start on a full tick.
    assign div_clr = (state == PUBLISH);

    userio_tick_div #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_div (
        .clk  (clk),
        .reset(reset),
        .clr  (div_clr),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shift_q    <= '1;
            prev_q     <= '1;
            joy_clk    <= 1'b0;
            joy_load   <= 1'b1;
            joystick1  <= '0;
            joystick2  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == PUBLISH) begin
                state <= GAP;
            end else if (tick) begin
                if (!enable) begin
                    // Park: a partially shifted frame is dropped, published words hold.
                    state    <= IDLE;
                    bit_cnt  <= '0;
                    gap_cnt  <= '0;
                    joy_clk  <= 1'b0;
                    joy_load <= 1'b1;
                end else begin
                    case (state)
                        IDLE: begin
                            state    <= LOAD;
                            joy_load <= 1'b0;
                            bit_cnt  <= '0;
                        end
                        LOAD: begin
                            state    <= SETTLE;
                            joy_load <= 1'b1;
                        end
                        SETTLE: begin
                            state <= SHIFT_LO;
                        end
                        SHIFT_LO: begin
                            shift_q[bit_cnt] <= joy_data;
                            joy_clk          <= 1'b1;
                            state            <= SHIFT_HI;
                        end
                        SHIFT_HI: begin
                            joy_clk <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                state      <= PUBLISH;
                                bit_cnt    <= '0;
                                frame_done <= 1'b1;
                                prev_q     <= shift_q;
                                if (FILTER == 0 || shift_q == prev_q) begin
                                    joystick1 <= to_joy_word(shift_q[JOY_BITS_PER_PLAYER-1:0]);
                                    joystick2 <= to_joy_word(shift_q[JOY_FRAME_BITS-1 -: JOY_BITS_PER_PLAYER]);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                state   <= SHIFT_LO;
                            end
                        end
                        GAP: begin
                            if (gap_cnt == GAP_LAST) begin
                                gap_cnt  <= '0;
                                state    <= LOAD;
                                joy_load <= 1'b0;
                            end else begin
                                gap_cnt <= gap_cnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_userio_db15_seq.sv
// Scoreboard bench for userio_db15_seq: FILTER=0 and FILTER=1 instances run in lockstep on one chain model.
module tb_userio_db15_seq;

    localparam int CD = 4;
    localparam int GT = 8;
    localparam int FRAME_PERIOD = (2 + 48 + GT) * CD + 1;  // 233

    localparam logic [23:0] PAT_REL = 24'hFFFFFF;
    localparam logic [23:0] PAT_A   = 24'hFFDFFE;  // bits 0 and 13 pressed
    localparam logic [23:0] PAT_B   = 24'hEFFFDF;  // bits 5 and 20 pressed

    typedef struct packed {
        logic [15:0] j1_a;
        logic [15:0] j2_a;
        logic [15:0] j1_b;
        logic [15:0] j2_b;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        joy_data;
    logic        jclk_a, load_a, fd_a;
    logic        jclk_b, load_b, fd_b;
    logic [15:0] j1_a, j2_a, j1_b, j2_b;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    logic [23:0] chain_pat = PAT_REL;
    logic [5:0]  chain_idx = '0;
    logic        chain_clk_q = 1'b0;

    always #5 clk = ~clk;

    userio_db15_seq #(.CLK_DIV(CD), .GAP_TICKS(GT), .FILTER(0)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .joy_data(joy_data),
        .joy_clk(jclk_a), .joy_load(load_a), .joystick1(j1_a), .joystick2(j2_a),
        .frame_done(fd_a)
    );

    userio_db15_seq #(.CLK_DIV(CD), .GAP_TICKS(GT), .FILTER(1)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .joy_data(joy_data),
        .joy_clk(jclk_b), .joy_load(load_b), .joystick1(j1_b), .joystick2(j2_b),
        .frame_done(fd_b)
    );

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Chain model: parallel load while joy_load is low, advance one bit per joy_clk rise.
    always @(negedge clk) begin
        if (!load_b) begin
            chain_idx <= '0;
        end else if (jclk_b && !chain_clk_q && chain_idx < 6'd24) begin
            chain_idx <= chain_idx + 6'd1;
        end
        chain_clk_q <= jclk_b;
    end

    assign joy_data = (chain_idx < 6'd24) ? chain_pat[chain_idx[4:0]] : 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] a1, input logic [15:0] a2,
                        input logic [15:0] b1, input logic [15:0] b2);
        exp_t e;
        e.j1_a = a1;
        e.j2_a = a2;
        e.j1_b = b1;
        e.j2_b = b2;
        sb.push_back(e);
    endtask

    task automatic wait_fd(input string name, input int budget, output int at);
        bit seen;
        seen = 0;
        at   = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (fd_b) begin
                seen = 1;
                at   = cyc;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: no frame_done within %0d cycles", name, budget);
        end
    endtask

    // Monitor: every frame_done pops one expectation and compares all four words.
    always @(negedge clk) begin
        if (!reset && fd_b) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame_done: at cycle %0d with empty scoreboard", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("fd_lockstep_f0", 32'(fd_a), 32'd1);
                check("j1_f0", 32'(j1_a), 32'(e.j1_a));
                check("j2_f0", 32'(j2_a), 32'(e.j2_a));
                check("j1_f1", 32'(j1_b), 32'(e.j1_b));
                check("j2_f1", 32'(j2_b), 32'(e.j2_b));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   k, ld_fall, ld_fall2, ld_low, clk_rise, clk_high, wave_err, fd_first;
    int   at, at_prev, n, anomalies, load_cyc;
    logic exp_ld, exp_ck, prev_ld, prev_ck;

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_j1_f0", 32'(j1_a), 32'h0);
        check("rst_j2_f0", 32'(j2_a), 32'h0);
        check("rst_j1_f1", 32'(j1_b), 32'h0);
        check("rst_j2_f1", 32'(j2_b), 32'h0);
        check("rst_joy_load", 32'(load_b), 32'h1);
        check("rst_joy_clk", 32'(jclk_b), 32'h0);
        check("rst_frame_done", 32'(fd_b), 32'h0);

        // Frames 1-2 with pattern A: FILTER=1 publishes only on the second, matching frame.
        chain_pat = PAT_A;
        push(16'h0001, 16'h0002, 16'h0000, 16'h0000);
        push(16'h0001, 16'h0002, 16'h0001, 16'h0002);
        reset  = 1'b0;
        enable = 1'b1;

        ld_fall = -1; ld_fall2 = -1; ld_low = 0; clk_rise = 0; clk_high = 0;
        wave_err = 0; fd_first = -1; prev_ld = 1'b1; prev_ck = 1'b0;
        do begin
            k      = cyc;
            exp_ld = !((k >= 4 && k < 8) || k >= 237);
            exp_ck = (k >= 12 && k < 204) && ((((k - 12) / 4) % 2) == 1);
            if (load_b !== exp_ld || jclk_b !== exp_ck || load_a !== exp_ld || jclk_a !== exp_ck)
                wave_err++;
            if (k < 237) begin
                if (!load_b) ld_low++;
                if (jclk_b)  clk_high++;
            end
            if (prev_ld && !load_b) begin
                if (ld_fall < 0)       ld_fall  = k;
                else if (ld_fall2 < 0) ld_fall2 = k;
            end
            if (!prev_ck && jclk_b) clk_rise++;
            if (fd_b && fd_first < 0) fd_first = k;
            prev_ld = load_b;
            prev_ck = jclk_b;
            @(negedge clk);
        end while (cyc <= 240);

        check("first_load_fall_cycle", 32'(ld_fall), 32'd4);
        check("load_low_cycles", 32'(ld_low), 32'd4);
        check("joy_clk_pulses", 32'(clk_rise), 32'd24);
        check("joy_clk_high_cycles", 32'(clk_high), 32'd96);
        check("waveform_errors", 32'(wave_err), 32'd0);
        check("first_frame_done_cycle", 32'(fd_first), 32'd204);
        check("second_load_fall_cycle", 32'(ld_fall2), 32'd237);

        wait_fd("frame2", 400, at);
        check("frame2_done_cycle", 32'(at), 32'(204 + FRAME_PERIOD));

        // Frame 3 changes pattern: FILTER=1 holds frame-2 words. Frame 4 repeats it: published.
        chain_pat = PAT_B;
        push(16'h0020, 16'h0100, 16'h0001, 16'h0002);
        wait_fd("frame3", 400, at);
        push(16'h0020, 16'h0100, 16'h0020, 16'h0100);
        wait_fd("frame4", 400, at);

        // Frame 5 is aborted by dropping enable mid-shift.
        chain_pat = PAT_A;
        n = 0;
        while (chain_idx != 6'd10 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit10", 32'(chain_idx), 32'd10);
        enable = 1'b0;
        repeat (CD) @(negedge clk);
        check("park_joy_clk", 32'(jclk_b), 32'h0);
        check("park_joy_load", 32'(load_b), 32'h1);
        anomalies = 0;
        repeat (300) begin
            @(negedge clk);
            if (jclk_b || !load_b || fd_b || fd_a) anomalies++;
        end
        check("park_anomalies", 32'(anomalies), 32'd0);
        check("park_hold_j1_f0", 32'(j1_a), 32'h0020);
        check("park_hold_j2_f0", 32'(j2_a), 32'h0100);
        check("park_hold_j1_f1", 32'(j1_b), 32'h0020);
        check("park_hold_j2_f1", 32'(j2_b), 32'h0100);

        // Re-enable: fresh frame from bit 0; FILTER=1 compares against frame 4, so it holds.
        push(16'h0001, 16'h0002, 16'h0020, 16'h0100);
        enable = 1'b1;
        n = 0;
        while (load_b && n < 2 * CD) begin
            @(negedge clk);
            n++;
        end
        check("reenable_load_within_clk_div", 32'(!load_b && n <= CD), 32'd1);
        load_cyc = cyc;
        wait_fd("frame6", 400, at);
        check("frame6_done_after_load", 32'(at - load_cyc), 32'd200);
        push(16'h0001, 16'h0002, 16'h0001, 16'h0002);
        wait_fd("frame7", 400, at);

        // Frame 8 is cut by reset with non-zero words on the outputs.
        n = 0;
        while (chain_idx != 6'd20 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit20", 32'(chain_idx), 32'd20);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_j1_f0", 32'(j1_a), 32'h0);
        check("midrst_j2_f0", 32'(j2_a), 32'h0);
        check("midrst_j1_f1", 32'(j1_b), 32'h0);
        check("midrst_j2_f1", 32'(j2_b), 32'h0);
        check("midrst_joy_load", 32'(load_b), 32'h1);
        check("midrst_joy_clk", 32'(jclk_b), 32'h0);
        check("midrst_frame_done", 32'(fd_b | fd_a), 32'h0);
        repeat (2) @(negedge clk);

        // All-released chain: three frames of zero words at the nominal frame period.
        chain_pat = PAT_REL;
        push(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        push(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        push(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        reset = 1'b0;
        wait_fd("rel_frame1", 400, at);
        check("rel_frame1_cycle", 32'(at), 32'd204);
        at_prev = at;
        wait_fd("rel_frame2", 400, at);
        check("rel_period1", 32'(at - at_prev), 32'(FRAME_PERIOD));
        at_prev = at;
        wait_fd("rel_frame3", 400, at);
        check("rel_period2", 32'(at - at_prev), 32'(FRAME_PERIOD));

        enable = 1'b0;
        repeat (2 * CD) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
